// File: rtl/mem_access_pkg.sv
// Shared Y86 MEM-stage definitions: widths, icodes, status codes, FSM state and
// the payloads captured while an access is outstanding.
package mem_access_pkg;

  localparam int unsigned BYTE  = 8;
  localparam int unsigned WORD  = 32;
  localparam int unsigned PCLEN = 32;
  localparam int unsigned STATW = 3;

  localparam logic [BYTE-1:0] IHALT   = 8'h00;
  localparam logic [BYTE-1:0] INOP    = 8'h01;
  localparam logic [BYTE-1:0] IRMMOVL = 8'h04;
  localparam logic [BYTE-1:0] IMRMOVL = 8'h05;
  localparam logic [BYTE-1:0] ICALL   = 8'h08;
  localparam logic [BYTE-1:0] IRET    = 8'h09;
  localparam logic [BYTE-1:0] IPUSHL  = 8'h0A;
  localparam logic [BYTE-1:0] IPOPL   = 8'h0B;

  localparam logic [BYTE-1:0] RNONE = 8'h0F;

  localparam logic [STATW-1:0] SAOK = 3'd1;
  localparam logic [STATW-1:0] SHLT = 3'd2;
  localparam logic [STATW-1:0] SADR = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HALTED
  } state_t;

  // Instruction fields forwarded to write-back
  typedef struct packed {
    logic [BYTE-1:0] icode;
    logic [BYTE-1:0] ra;
    logic [BYTE-1:0] rb;
    logic [WORD-1:0] val_e;
  } wb_rec_t;

  // Data-memory request held stable while waiting for ready
  typedef struct packed {
    logic            rd;
    logic            we;
    logic [WORD-1:0] addr;
    logic [WORD-1:0] wdata;
  } dmem_cmd_t;

endpackage

// File: rtl/mem_ctrl_decode.sv
// Combinational access decode for the MEM stage.
// Ports: icode/val_a/val_e/val_p in; is_read, is_write, addr, wdata, bad_addr out.
module mem_ctrl_decode
  import mem_access_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = 4096
) (
  input  logic [BYTE-1:0]  icode,
  input  logic [WORD-1:0]  val_a,
  input  logic [WORD-1:0]  val_e,
  input  logic [PCLEN-1:0] val_p,
  output logic             is_read,
  output logic             is_write,
  output logic [WORD-1:0]  addr,
  output logic [WORD-1:0]  wdata,
  output logic             bad_addr
);

  // Highest address at which a full word still fits
  localparam logic [WORD-1:0] LAST_WORD = WORD'(DMEM_BYTES - 4);

  always_comb begin
    is_read  = 1'b0;
    is_write = 1'b0;
    addr     = val_e;
    wdata    = val_a;
    case (icode)
      IRMMOVL, IPUSHL: is_write = 1'b1;
      ICALL: begin
        is_write = 1'b1;
        wdata    = WORD'(val_p);
      end
      IMRMOVL: is_read = 1'b1;
      IRET, IPOPL: begin
        is_read = 1'b1;
        addr    = val_a;
      end
      default: ;
    endcase
    bad_addr = (is_read || is_write) &&
               ((addr[1:0] != 2'b00) || (addr > LAST_WORD));
  end

endmodule

// File: rtl/mem_access.sv
// Y86 MEM stage: issues data-memory accesses over req/ready, stalls upstream
// while an access is outstanding and registers the write-back record.
// Ports: clk, rst; mem_* from EX/MEM; mem_stall to upstream; dmem_* memory
// handshake (request side combinational); wb_* registered write-back record.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = 4096,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE-1:0]   mem_icode,
  input  logic [BYTE-1:0]   mem_rA,
  input  logic [BYTE-1:0]   mem_rB,
  input  logic [WORD-1:0]   mem_valA,
  input  logic [PCLEN-1:0]  mem_valP,
  input  logic [WORD-1:0]   mem_valE,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [WORD-1:0]   dmem_addr,
  output logic [WORD-1:0]   dmem_wdata,
  input  logic              dmem_ready,
  input  logic [WORD-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic [BYTE-1:0]   wb_icode,
  output logic [BYTE-1:0]   wb_rA,
  output logic [BYTE-1:0]   wb_rB,
  output logic [WORD-1:0]   wb_valE,
  output logic [WORD-1:0]   wb_valM,
  output logic [STATW-1:0]  wb_stat
);

  localparam int unsigned     CNTW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [CNTW-1:0]   cnt, cnt_nxt;
  dmem_cmd_t         pend_cmd;
  wb_rec_t           pend_rec;

  logic              d_read, d_write, d_bad;
  logic [WORD-1:0]   d_addr, d_wdata;

  logic              cap_pend, rec_wr, rec_from_pend;
  logic [STATW-1:0]  rec_stat;
  logic [WORD-1:0]   rec_valm;
  wb_rec_t           rec_src;

  mem_ctrl_decode #(.DMEM_BYTES(DMEM_BYTES)) u_decode (
    .icode    (mem_icode),
    .val_a    (mem_valA),
    .val_e    (mem_valE),
    .val_p    (mem_valP),
    .is_read  (d_read),
    .is_write (d_write),
    .addr     (d_addr),
    .wdata    (d_wdata),
    .bad_addr (d_bad)
  );

  // State and timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, memory handshake and record selection
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cap_pend      = 1'b0;
    rec_wr        = 1'b0;
    rec_from_pend = 1'b0;
    rec_stat      = SAOK;
    rec_valm      = '0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    dmem_addr     = '0;
    dmem_wdata    = '0;
    mem_stall     = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_icode == IHALT) begin
          rec_wr    = 1'b1;
          rec_stat  = SHLT;
          state_nxt = S_HALTED;
        end else if (d_bad) begin
          rec_wr    = 1'b1;
          rec_stat  = SADR;
          state_nxt = S_HALTED;
        end else if ((d_read || d_write) && !rst) begin
          // rst gate keeps the request low while reset is asserted
          dmem_req   = 1'b1;
          dmem_we    = d_write;
          dmem_addr  = d_addr;
          dmem_wdata = d_wdata;
          if (dmem_ready) begin
            rec_wr = 1'b1;
            if (d_read) rec_valm = dmem_rdata;
          end else begin
            mem_stall = 1'b1;
            cap_pend  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_WAIT;
          end
        end else begin
          rec_wr = 1'b1;
        end
      end
      S_WAIT: begin
        dmem_req      = 1'b1;
        dmem_we       = pend_cmd.we;
        dmem_addr     = pend_cmd.addr;
        dmem_wdata    = pend_cmd.wdata;
        rec_from_pend = 1'b1;
        if (dmem_ready) begin
          rec_wr    = 1'b1;
          if (pend_cmd.rd) rec_valm = dmem_rdata;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          mem_stall = 1'b1;
          rec_wr    = 1'b1;
          rec_stat  = SADR;
          cnt_nxt   = '0;
          state_nxt = S_HALTED;
        end else begin
          mem_stall = 1'b1;
          cnt_nxt   = cnt + 1'b1;
        end
      end
      S_HALTED: mem_stall = 1'b1;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rec_src = rec_from_pend ? pend_rec
                            : '{icode: mem_icode, ra: mem_rA, rb: mem_rB, val_e: mem_valE};
  end

  // Snapshot of the outstanding access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cmd <= '0;
      pend_rec <= '0;
    end else if (cap_pend) begin
      pend_cmd <= '{rd: d_read, we: d_write, addr: d_addr, wdata: d_wdata};
      pend_rec <= '{icode: mem_icode, ra: mem_rA, rb: mem_rB, val_e: mem_valE};
    end
  end

  // Write-back record; fields hold when no record is written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_icode <= INOP;
      wb_rA    <= RNONE;
      wb_rB    <= RNONE;
      wb_valE  <= '0;
      wb_valM  <= '0;
      wb_stat  <= SAOK;
    end else begin
      wb_valid <= rec_wr;
      if (rec_wr) begin
        wb_icode <= rec_src.icode;
        wb_rA    <= rec_src.ra;
        wb_rB    <= rec_src.rb;
        wb_valE  <= rec_src.val_e;
        wb_valM  <= rec_valm;
        wb_stat  <= rec_stat;
      end
    end
  end

endmodule
